// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Match sequencer for the two-player pong display. Keeps the BCD
//            scores, the serve owner and the text-region enables for the
//            overlay stage, and walks NEWGAME -> PLAY -> NEWBALL/OVER using a
//            frame-tick pause timer.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            refr_tick  - one-cycle pulse per video frame
//            btn_start  - debounced start button (level)
//            point_a/b  - one-cycle score pulses from the graphics stage
//            dig0_A/dig1_A, dig0_B/dig1_B - BCD score digits (ones/tens)
//            ball       - serve owner: 00 none, 01 A, 10 B
//            gra_still  - freeze ball at serve position
//            show_rule / show_over - overlay text region enables
//            game_state - 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 5,
    parameter int PAUSE_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic       btn_start,
    input  logic       point_a,
    input  logic       point_b,
    output logic [3:0] dig0_A,
    output logic [3:0] dig1_A,
    output logic [3:0] dig0_B,
    output logic [3:0] dig1_B,
    output logic [1:0] ball,
    output logic       gra_still,
    output logic       show_rule,
    output logic       show_over,
    output logic [1:0] game_state
);

    localparam int             c_TIMER_W   = $clog2(PAUSE_TICKS + 1);
    localparam logic [c_TIMER_W-1:0] c_PAUSE     = c_TIMER_W'(PAUSE_TICKS);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ZERO = '0;
    localparam logic [6:0]     c_WIN       = 7'(WIN_SCORE);

    localparam logic [1:0] c_ST_NEWGAME = 2'b00;
    localparam logic [1:0] c_ST_PLAY    = 2'b01;
    localparam logic [1:0] c_ST_NEWBALL = 2'b10;
    localparam logic [1:0] c_ST_OVER    = 2'b11;

    localparam logic [1:0] c_BALL_NONE = 2'b00;
    localparam logic [1:0] c_BALL_A    = 2'b01;
    localparam logic [1:0] c_BALL_B    = 2'b10;

    // Registered state; every output is driven straight from one of these.
    logic [1:0]           r_state;
    logic [7:0]           r_score_a;   // {tens, ones}
    logic [7:0]           r_score_b;
    logic [1:0]           r_ball;
    logic                 r_gra_still;
    logic                 r_show_rule;
    logic                 r_show_over;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_btn_prev;

    logic [1:0]           w_state_nxt;
    logic [7:0]           w_score_a_nxt;
    logic [7:0]           w_score_b_nxt;
    logic [1:0]           w_ball_nxt;
    logic                 w_gra_still_nxt;
    logic                 w_show_rule_nxt;
    logic                 w_show_over_nxt;
    logic [c_TIMER_W-1:0] w_timer_nxt;

    logic                 w_start_edge;
    logic [7:0]           w_a_inc;
    logic [7:0]           w_b_inc;
    logic [6:0]           w_a_inc_bin;
    logic [6:0]           w_b_inc_bin;
    logic                 w_pause_done;

    // Two-digit BCD increment that saturates at 99.
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_start_edge = btn_start & ~r_btn_prev;
    assign w_a_inc      = f_bcd_inc(r_score_a);
    assign w_b_inc      = f_bcd_inc(r_score_b);
    assign w_a_inc_bin  = 7'(w_a_inc[7:4]) * 7'd10 + 7'(w_a_inc[3:0]);
    assign w_b_inc_bin  = 7'(w_b_inc[7:4]) * 7'd10 + 7'(w_b_inc[3:0]);

    // The pause ends on the tick that takes the timer to zero, so the next
    // state is visible the cycle right after the last tick.
    assign w_pause_done = (r_timer == c_TIMER_ZERO) ||
                          (refr_tick && (r_timer == c_TIMER_ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_NEWGAME;
            r_score_a   <= 8'h00;
            r_score_b   <= 8'h00;
            r_ball      <= c_BALL_NONE;
            r_gra_still <= 1'b1;
            r_show_rule <= 1'b1;
            r_show_over <= 1'b0;
            r_timer     <= c_TIMER_ZERO;
            r_btn_prev  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_a   <= w_score_a_nxt;
            r_score_b   <= w_score_b_nxt;
            r_ball      <= w_ball_nxt;
            r_gra_still <= w_gra_still_nxt;
            r_show_rule <= w_show_rule_nxt;
            r_show_over <= w_show_over_nxt;
            r_timer     <= w_timer_nxt;
            r_btn_prev  <= btn_start;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_score_a_nxt   = r_score_a;
        w_score_b_nxt   = r_score_b;
        w_ball_nxt      = r_ball;
        w_gra_still_nxt = r_gra_still;
        w_show_rule_nxt = r_show_rule;
        w_show_over_nxt = r_show_over;
        w_timer_nxt     = r_timer;

        case (r_state)
            c_ST_NEWGAME: begin
                w_show_rule_nxt = 1'b1;
                w_gra_still_nxt = 1'b1;
                w_ball_nxt      = c_BALL_NONE;
                if (w_start_edge) begin
                    w_state_nxt     = c_ST_PLAY;
                    w_score_a_nxt   = 8'h00;
                    w_score_b_nxt   = 8'h00;
                    w_ball_nxt      = c_BALL_A;
                    w_show_rule_nxt = 1'b0;
                    w_gra_still_nxt = 1'b0;
                end
            end

            c_ST_PLAY: begin
                w_gra_still_nxt = 1'b0;
                // point_a has priority; a coincident point_b is dropped.
                if (point_a || point_b) begin
                    w_gra_still_nxt = 1'b1;
                    w_timer_nxt     = c_PAUSE;
                    if (point_a) begin
                        w_score_a_nxt = w_a_inc;
                        if (w_a_inc_bin == c_WIN) begin
                            w_state_nxt     = c_ST_OVER;
                            w_show_over_nxt = 1'b1;
                            w_ball_nxt      = c_BALL_NONE;
                        end else begin
                            w_state_nxt = c_ST_NEWBALL;
                            w_ball_nxt  = c_BALL_B;
                        end
                    end else begin
                        w_score_b_nxt = w_b_inc;
                        if (w_b_inc_bin == c_WIN) begin
                            w_state_nxt     = c_ST_OVER;
                            w_show_over_nxt = 1'b1;
                            w_ball_nxt      = c_BALL_NONE;
                        end else begin
                            w_state_nxt = c_ST_NEWBALL;
                            w_ball_nxt  = c_BALL_A;
                        end
                    end
                end
            end

            c_ST_NEWBALL: begin
                if (w_pause_done) begin
                    w_state_nxt     = c_ST_PLAY;
                    w_gra_still_nxt = 1'b0;
                    w_timer_nxt     = c_TIMER_ZERO;
                end else if (refr_tick) begin
                    w_timer_nxt = r_timer - c_TIMER_ONE;
                end
            end

            default: begin // c_ST_OVER
                if (w_pause_done) begin
                    w_state_nxt     = c_ST_NEWGAME;
                    w_show_over_nxt = 1'b0;
                    w_show_rule_nxt = 1'b1;
                    w_timer_nxt     = c_TIMER_ZERO;
                end else if (refr_tick) begin
                    w_timer_nxt = r_timer - c_TIMER_ONE;
                end
            end
        endcase
    end

    assign dig0_A     = r_score_a[3:0];
    assign dig1_A     = r_score_a[7:4];
    assign dig0_B     = r_score_b[3:0];
    assign dig1_B     = r_score_b[7:4];
    assign ball       = r_ball;
    assign gra_still  = r_gra_still;
    assign show_rule  = r_show_rule;
    assign show_over  = r_show_over;
    assign game_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Directed testbench for pong_game_ctrl. One instance uses the
//            default parameters; a second uses WIN_SCORE=99 with a short
//            pause to reach the two-digit BCD boundaries quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic refr_tick, btn_start, point_a, point_b;
    logic refr_tick2, btn_start2, point_a2, point_b2;

    logic [3:0] d0a, d1a, d0b, d1b, e0a, e1a, e0b, e1b;
    logic [1:0] ball, ball2, gst, gst2;
    logic       gs, sr, so, gs2, sr2, so2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn_start(btn_start),
        .point_a(point_a), .point_b(point_b),
        .dig0_A(d0a), .dig1_A(d1a), .dig0_B(d0b), .dig1_B(d1b),
        .ball(ball), .gra_still(gs), .show_rule(sr), .show_over(so),
        .game_state(gst)
    );

    pong_game_ctrl #(.WIN_SCORE(99), .PAUSE_TICKS(2)) dut99 (
        .clk(clk), .reset(reset), .refr_tick(refr_tick2), .btn_start(btn_start2),
        .point_a(point_a2), .point_b(point_b2),
        .dig0_A(e0a), .dig1_A(e1a), .dig0_B(e0b), .dig1_B(e1b),
        .ball(ball2), .gra_still(gs2), .show_rule(sr2), .show_over(so2),
        .game_state(gst2)
    );

    // {state, A tens/ones, B tens/ones, ball, gra_still, show_rule, show_over}
    logic [22:0] obs, obs2;
    assign obs  = {gst,  d1a, d0a, d1b, d0b, ball,  gs,  sr,  so};
    assign obs2 = {gst2, e1a, e0a, e1b, e0b, ball2, gs2, sr2, so2};

    function automatic logic [22:0] exp_v(input logic [1:0] st, input logic [7:0] a,
                                          input logic [7:0] b, input logic [1:0] bl,
                                          input logic g, input logic r, input logic o);
        return {st, a, b, bl, g, r, o};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Score a point on the default instance and sit out the whole pause.
    task automatic give_point(input logic is_a);
        if (is_a) point_a = 1'b1; else point_b = 1'b1;
        cyc(1);
        point_a = 1'b0; point_b = 1'b0;
        refr_tick = 1'b1;
        cyc(120);
        refr_tick = 1'b0;
    endtask

    task automatic give_point2;
        point_a2 = 1'b1;
        cyc(1);
        point_a2 = 1'b0;
        refr_tick2 = 1'b1;
        cyc(2);
        refr_tick2 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        refr_tick = 0; btn_start = 0; point_a = 0; point_b = 0;
        refr_tick2 = 0; btn_start2 = 0; point_a2 = 0; point_b2 = 0;
        cyc(3);
        vectors++;
        if (obs !== exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0));
        end
        reset = 1'b1;
        cyc(2);
    endtask

    task automatic test_start;
        btn_start = 1'b1;
        cyc(1);
        vectors++;
        if (obs !== exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL start_edge: got %h expected %h", obs, exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0));
        end
        cyc(49);
        vectors++;
        if (obs !== exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL start_hold: got %h expected %h", obs, exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0));
        end
    endtask

    task automatic test_point_a;
        point_a = 1'b1;
        cyc(1);
        point_a = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b10, 8'h01, 8'h00, 2'b10, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL point_a: got %h expected %h", obs, exp_v(2'b10, 8'h01, 8'h00, 2'b10, 1, 0, 0));
        end
        for (int i = 0; i < 119; i++) begin
            refr_tick = 1'b1; cyc(1);
            refr_tick = 1'b0; cyc(1);
        end
        vectors++;
        if (obs !== exp_v(2'b10, 8'h01, 8'h00, 2'b10, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL pause_119_ticks: got %h expected %h", obs, exp_v(2'b10, 8'h01, 8'h00, 2'b10, 1, 0, 0));
        end
        refr_tick = 1'b1; cyc(1);
        refr_tick = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b01, 8'h01, 8'h00, 2'b10, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL pause_120_ticks: got %h expected %h", obs, exp_v(2'b01, 8'h01, 8'h00, 2'b10, 0, 0, 0));
        end
    endtask

    task automatic test_point_b_newball;
        point_b = 1'b1;
        cyc(1);
        point_b = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b10, 8'h01, 8'h01, 2'b01, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL point_b: got %h expected %h", obs, exp_v(2'b10, 8'h01, 8'h01, 2'b01, 1, 0, 0));
        end
        // Points during the pause must be ignored.
        point_b = 1'b1; cyc(1);
        point_a = 1'b1; point_b = 1'b0; cyc(1);
        point_a = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b10, 8'h01, 8'h01, 2'b01, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL newball_ignore: got %h expected %h", obs, exp_v(2'b10, 8'h01, 8'h01, 2'b01, 1, 0, 0));
        end
        refr_tick = 1'b1;
        cyc(120);
        refr_tick = 1'b0;
        vectors++;
        if (gst !== 2'b01) begin
            miscompares++;
            $display("FAIL newball_exit: got state %b expected 01", gst);
        end
    endtask

    task automatic test_simultaneous_win;
        give_point(1'b1); give_point(1'b1); give_point(1'b1); give_point(1'b0);
        vectors++;
        if (obs !== exp_v(2'b01, 8'h04, 8'h02, 2'b01, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL score_4_2: got %h expected %h", obs, exp_v(2'b01, 8'h04, 8'h02, 2'b01, 0, 0, 0));
        end
        point_a = 1'b1; point_b = 1'b1;
        cyc(1);
        point_a = 1'b0; point_b = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b11, 8'h05, 8'h02, 2'b00, 1, 0, 1)) begin
            miscompares++;
            $display("FAIL simultaneous_win: got %h expected %h", obs, exp_v(2'b11, 8'h05, 8'h02, 2'b00, 1, 0, 1));
        end
        // Fresh start edge and a point pulse while in OVER: both ignored.
        btn_start = 1'b0; cyc(1);
        btn_start = 1'b1; point_b = 1'b1; cyc(1);
        point_b = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b11, 8'h05, 8'h02, 2'b00, 1, 0, 1)) begin
            miscompares++;
            $display("FAIL over_ignore: got %h expected %h", obs, exp_v(2'b11, 8'h05, 8'h02, 2'b00, 1, 0, 1));
        end
        refr_tick = 1'b1;
        cyc(119);
        vectors++;
        if (gst !== 2'b11) begin
            miscompares++;
            $display("FAIL over_119_ticks: got state %b expected 11", gst);
        end
        cyc(1);
        refr_tick = 1'b0;
        vectors++;
        if (obs !== exp_v(2'b00, 8'h05, 8'h02, 2'b00, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL over_exit: got %h expected %h", obs, exp_v(2'b00, 8'h05, 8'h02, 2'b00, 1, 1, 0));
        end
        // Button still held from before: no edge, so no restart.
        cyc(5);
        vectors++;
        if (obs !== exp_v(2'b00, 8'h05, 8'h02, 2'b00, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL newgame_hold: got %h expected %h", obs, exp_v(2'b00, 8'h05, 8'h02, 2'b00, 1, 1, 0));
        end
        btn_start = 1'b0; cyc(1);
        btn_start = 1'b1; cyc(1);
        vectors++;
        if (obs !== exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL restart: got %h expected %h", obs, exp_v(2'b01, 8'h00, 8'h00, 2'b01, 0, 0, 0));
        end
        btn_start = 1'b0;
    endtask

    task automatic test_reset_midgame;
        point_a = 1'b1; cyc(1);
        point_a = 1'b0;
        refr_tick = 1'b1; cyc(63);
        refr_tick = 1'b0;
        vectors++;
        if (dut.r_timer !== 7'd57) begin
            miscompares++;
            $display("FAIL timer_57: got %0d expected 57", dut.r_timer);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (obs !== exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0) || dut.r_timer !== 7'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h timer %0d expected %h timer 0", obs, dut.r_timer, exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0));
        end
        cyc(3);
        reset = 1'b1;
        cyc(5);
        vectors++;
        if (obs !== exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0)) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h expected %h", obs, exp_v(2'b00, 8'h00, 8'h00, 2'b00, 1, 1, 0));
        end
    endtask

    task automatic test_bcd_boundary;
        btn_start2 = 1'b1; cyc(1);
        for (int i = 0; i < 9; i++) give_point2();
        vectors++;
        if (obs2 !== exp_v(2'b01, 8'h09, 8'h00, 2'b10, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL bcd_09: got %h expected %h", obs2, exp_v(2'b01, 8'h09, 8'h00, 2'b10, 0, 0, 0));
        end
        point_a2 = 1'b1; cyc(1);
        point_a2 = 1'b0;
        vectors++;
        if (obs2 !== exp_v(2'b10, 8'h10, 8'h00, 2'b10, 1, 0, 0)) begin
            miscompares++;
            $display("FAIL bcd_carry_10: got %h expected %h", obs2, exp_v(2'b10, 8'h10, 8'h00, 2'b10, 1, 0, 0));
        end
        refr_tick2 = 1'b1; cyc(2);
        refr_tick2 = 1'b0;
        for (int i = 0; i < 88; i++) give_point2();
        vectors++;
        if (obs2 !== exp_v(2'b01, 8'h98, 8'h00, 2'b10, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL bcd_98: got %h expected %h", obs2, exp_v(2'b01, 8'h98, 8'h00, 2'b10, 0, 0, 0));
        end
        point_a2 = 1'b1; cyc(1);
        point_a2 = 1'b0;
        vectors++;
        if (obs2 !== exp_v(2'b11, 8'h99, 8'h00, 2'b00, 1, 0, 1)) begin
            miscompares++;
            $display("FAIL win_99: got %h expected %h", obs2, exp_v(2'b11, 8'h99, 8'h00, 2'b00, 1, 0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_point_a();
        test_point_b_newball();
        test_simultaneous_win();
        test_reset_midgame();
        test_bcd_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-level controller for the two-player pong display.
- Sits directly upstream of the text overlay stage and feeds it:
  - the four BCD score digits
  - the ball/serve indicator
  - the region-enable controls for rule and game-over text.
- Consumes point pulses from the ball/paddle graphics stage and a debounced start button.
- Sequences the match through new-game, play, new-ball and game-over states, with a frame-tick based pause timer.

Parameters:
- WIN_SCORE, 5, points (binary, legal 1..99) at which a player wins; checked against the post-increment score.
- PAUSE_TICKS, 120, number of refresh ticks spent in NEWBALL and in OVER (2 s at 60 Hz).

Ports:
- clk  in  1  system clock, 100 MHz; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- refr_tick  in  1  one-cycle pulse at start of each video frame (60 Hz).
- btn_start  in  1  debounced start button, level.
- point_a  in  1  one-cycle pulse: player A scored.
- point_b  in  1  one-cycle pulse: player B scored.
- dig0_A  out  4  player A score, ones digit (BCD).
- dig1_A  out  4  player A score, tens digit (BCD).
- dig0_B  out  4  player B score, ones digit.
- dig1_B  out  4  player B score, tens digit.
- ball  out  2  serve owner: 00 none, 01 A serves, 10 B serves; 11 never driven.
- gra_still  out  1  1 = graphics stage holds ball frozen at serve position.
- show_rule  out  1  enable rule text region.
- show_over  out  1  enable game-over text region.
- game_state  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER (debug/LED).

Behaviour:
- All outputs are registered; no combinational path from any input to any output.
- Reset (reset=0, asynchronous) values:
  - state NEWGAME
  - all digits 0
  - ball 00
  - gra_still 1, show_rule 1, show_over 0
  - pause timer 0, button history register 0.
- Start edge detection: btn_prev registered each clk; start_edge = btn_start & ~btn_prev. Holding the button produces exactly one edge.
- NEWGAME:
  - show_rule 1, gra_still 1, ball 00; digits hold their last values.
  - start_edge -> PLAY: clear all four digits to 0, set ball 01, show_rule 0, gra_still 0. All of this in the same cycle as the transition.
- PLAY:
  - gra_still 0.
  - point_a -> increment A score.
  - point_b (only when point_a is 0) -> increment B score.
  - Simultaneous point_a and point_b: A wins priority; point_b is dropped.
  - After the increment:
    - new score == WIN_SCORE -> OVER; show_over 1, ball 00.
    - otherwise -> NEWBALL; ball = 10 after point_a, 01 after point_b (the conceded-against player receives serve).
  - In both cases gra_still 1 and the timer loads PAUSE_TICKS.
- NEWBALL:
  - Timer decrements by 1 on each refr_tick.
  - Timer == 0 -> PLAY, gra_still 0.
  - Point pulses are ignored.
- OVER:
  - Timer decrements on refr_tick.
  - Timer == 0 -> NEWGAME; show_over 0, show_rule 1.
  - Digits hold the final score until the next start.
  - Point pulses and start_edge are ignored.
- BCD increment:
  - ones digit 9 -> 0 with tens +1.
  - 99 saturates at 99; no wrap, no 1xx.
  - Digits are never outside 0..9.
- Win compare: binary value (tens*10 + ones) of the incremented score vs WIN_SCORE, evaluated on the incremented value, in the same cycle.
- Timer width: ceil(log2(PAUSE_TICKS+1)) bits. refr_tick arriving in the same cycle as the load is ignored (load wins).
- Reset asserted mid-game: immediate return to reset values regardless of state or timer.

Test Plan:
- Reset then release; hold btn_start=1 for 50 cycles -> exactly one PLAY entry; digits 0/0/0/0, ball=01, show_rule=0, gra_still=0 one cycle after the edge.
- In PLAY, pulse point_a -> A=01, state NEWBALL, ball=10, gra_still=1. Then issue 120 refr_ticks -> PLAY on the cycle after the 120th tick, gra_still=0.
- In PLAY with A=04, B=02, pulse point_a and point_b in the same cycle -> A=05, B=02 unchanged, state OVER, show_over=1, ball=00. After 120 ticks -> NEWGAME, show_rule=1, digits still 05/02.
- WIN_SCORE=99, drive A to 09 then one point -> dig1_A=1, dig0_A=0. Drive A to 98 then one point -> OVER with A=99.
- Pulse point_b while in NEWBALL and while in OVER -> scores unchanged, no state change.
- Assert reset in NEWBALL with timer=57 -> state NEWGAME, digits 0, timer 0 while reset is low. Release -> stays NEWGAME until a start edge.
